dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Two-port round-robin arbiter and access sequencer for the single-port data memory (dmem).
//   Port 0 is the core load/store unit; port 1 is a secondary master (debug/DMA loader).
//   Accepts one request at a time, drives dmem for one cycle and returns a one-cycle response
//   (read data or write ack) to the requester that owned the access.
// PARAMETERS
//   AW      32  address width (byte address, word-aligned accesses only)
//   DW      32  data width
// PORTS
//   clk        in   1   system clock, all state updates on rising edge
//   reset      in   1   synchronous, active-high reset
//   m0_req     in   1   port 0 request; held with m0_we/m0_addr/m0_wdata until m0_gnt
//   m0_we      in   1   port 0 write enable (1=store, 0=load)
//   m0_addr    in   AW  port 0 byte address
//   m0_wdata   in   DW  port 0 store data
//   m0_gnt     out  1   port 0 request accepted this cycle (combinational)
//   m0_rvalid  out  1   port 0 response valid, one-cycle pulse
//   m0_rdata   out  DW  port 0 load data, valid with m0_rvalid
//   m0_err     out  1   port 0 misaligned-access error, valid with m0_rvalid
//   m1_*       --   --  identical set for port 1 (m1_req, m1_we, m1_addr, m1_wdata, m1_gnt,
//                       m1_rvalid, m1_rdata, m1_err)
//   mem_we     out  1   dmem write enable
//   mem_a      out  AW  dmem address
//   mem_wd     out  DW  dmem write data
//   mem_rd     in   DW  dmem read data (combinational from mem_a)
// BEHAVIOUR
//   FSM states: IDLE, ACCESS, RESP. Reset -> IDLE.
//   Accept: gnt may assert only in IDLE or RESP. Winner = sole requester; if both request,
//     the port NOT granted last (rr_last). rr_last resets to 1, so port 0 wins first tie.
//   On gnt edge: latch owner, we, addr, wdata; rr_last <= owner; next state ACCESS.
//     No gnt in IDLE/RESP -> IDLE.
//   ACCESS (1 cycle): mem_a = latched addr, mem_wd = latched wdata,
//     mem_we = latched we & aligned. Read data mem_rd captured at end of cycle. Next: RESP.
//   RESP (1 cycle): owner's rvalid=1; rdata = captured mem_rd for loads, 0 for stores;
//     other port's rvalid=0. A new gnt may occur in this same cycle (back-to-back).
//   Latency: gnt in cycle N -> mem access in N+1 -> rvalid in N+2. Peak 1 access / 2 cycles.
//   Misaligned (addr[1:0]!=0): accepted normally; mem_we forced 0; RESP gives rvalid=1,
//     err=1, rdata=0. err=0 on every aligned response.
//   Requester may drop req before gnt; no access. Inputs ignored outside gnt cycle.
//   mem_we is 0 in IDLE and RESP; mem_a/mem_wd hold last values outside ACCESS.
//   Reset values: all gnt/rvalid/err = 0, rdata = 0, mem_we = 0, mem_a = 0, mem_wd = 0,
//     rr_last = 1, state IDLE. gnt forced 0 while reset is high.
//   Reset mid-operation: reset high in ACCESS forces mem_we = 0 that cycle (write dropped);
//     pending response discarded, no rvalid after reset.
//   Address is passed unmodified (full AW bits) to mem_a; no range check here.
// TESTING
//   1 m0 store 0x4<-A5A5A5A5, then m0 load 0x4 -> m0_gnt, mem_we=1 one cycle, load
//     rvalid 2 cycles after gnt with rdata=A5A5A5A5, err=0.
//   2 m0 and m1 request same cycle (m0 load 0x8, m1 store 0xC<-DEADBEAF) -> m0 granted
//     first, m1 granted in m0's RESP cycle; m1_rvalid 2 cycles later; m0 never sees m1 resp.
//   3 Both hold req continuously for 6 grants -> grants alternate 0,1,0,1,0,1, one per 2 cycles.
//   4 m1 store to 0x6 <-12345678 -> m1_rvalid with m1_err=1, mem_we never 1;
//     load 0x4 still returns prior value.
//   5 m0 store 0x10<-5A5A5A5A, assert reset during ACCESS -> mem_we=0, no rvalid,
//     all outputs 0 next cycle; load 0x10 after reset returns old contents.
//   6 m0_req pulsed 1 cycle while FSM in ACCESS, then dropped -> no gnt, no access.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port round-robin arbiter and access sequencer for the
//                single-port data memory. Port 0 is the core load/store unit,
//                port 1 a secondary master (debug/DMA loader). One request is
//                accepted at a time; dmem is driven for one cycle and a
//                one-cycle response (read data or write ack) is returned to
//                the owning port. Grant in cycle N -> memory access in N+1 ->
//                response in N+2.
//  Ports       : clk, reset (sync, active-high)
//                m0_*/m1_* : req/we/addr/wdata in, gnt/rvalid/rdata/err out
//                mem_we/mem_a/mem_wd out, mem_rd in (combinational read)
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,

    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_rr_last;   // port granted most recently (1 = port 1)
    logic          r_owner;     // port owning the in-flight access
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;     // load data captured at the end of ACCESS

    logic          w_can_accept;
    logic          w_pick1;
    logic          w_gnt_any;
    logic          w_aligned;
    logic          w_resp;

    // A new request may be taken while idle or while the previous response
    // is being returned, giving back-to-back accesses every two cycles.
    assign w_can_accept = !reset && ((r_state == S_IDLE) || (r_state == S_RESP));

    // Port 1 wins when it is the sole requester, or on a tie when port 0
    // was the one served last.
    assign w_pick1   = m1_req && (!m0_req || !r_rr_last);
    assign m1_gnt    = w_can_accept && w_pick1;
    assign m0_gnt    = w_can_accept && m0_req && !w_pick1;
    assign w_gnt_any = m0_gnt || m1_gnt;

    assign w_aligned = (r_addr[1:0] == 2'b00);

    always_comb begin
        w_state_nxt = r_state;
        mem_we      = 1'b0;
        w_resp      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_any) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_state_nxt = S_RESP;
                // Misaligned stores are suppressed; reset drops the write.
                mem_we      = r_we && w_aligned && !reset;
            end
            S_RESP: begin
                w_resp      = !reset;
                w_state_nxt = w_gnt_any ? S_ACCESS : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Address and data registers only change on a grant, so the memory bus
    // holds its last values outside the ACCESS cycle.
    assign mem_a  = r_addr;
    assign mem_wd = r_wdata;

    assign m0_rvalid = w_resp && !r_owner;
    assign m1_rvalid = w_resp &&  r_owner;
    assign m0_rdata  = m0_rvalid ? r_rdata : '0;
    assign m1_rdata  = m1_rvalid ? r_rdata : '0;
    assign m0_err    = m0_rvalid && !w_aligned;
    assign m1_err    = m1_rvalid && !w_aligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rr_last <= 1'b1;
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt_any) begin
                r_owner   <= m1_gnt;
                r_rr_last <= m1_gnt;
                r_we      <= m1_gnt ? m1_we    : m0_we;
                r_addr    <= m1_gnt ? m1_addr  : m0_addr;
                r_wdata   <= m1_gnt ? m1_wdata : m0_wdata;
            end
            if (r_state == S_ACCESS) begin
                // Stores and misaligned accesses return zero data.
                r_rdata <= (!r_we && w_aligned) ? mem_rd : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter. A transaction-level
//                model (queue of granted transactions, shadow memory) predicts
//                grants, memory strobes and responses every cycle; directed
//                sequences add hand-computed expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd, mem_rd;

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Simple data memory: combinational read, synchronous write.
    logic [DW-1:0] dmem [0:63] = '{default: '0};
    assign mem_rd = dmem[mem_a[7:2]];
    always @(posedge clk) if (mem_we) dmem[mem_a[7:2]] <= mem_wd;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        int            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gcyc;
        logic [DW-1:0] rdata;
    } txn_t;

    txn_t          q[$];
    logic [DW-1:0] shadow [int];
    int            cyc = 0;
    int            rr = 1;
    bit            prev_reset = 1'b1;

    // Observation logs for the directed checks.
    int            r_cnt[2] = '{0, 0};
    int            r_cyc[2] = '{0, 0};
    logic [DW-1:0] r_data[2];
    logic          r_err[2];
    int            g_cnt[2] = '{0, 0};
    int            we_cnt = 0;
    int            gport[$];
    int            gcy[$];

    always @(negedge clk) begin : cmp
        int acc_i, rsp_i, key;
        bit e_g0, e_g1, e_we, e_rv0, e_rv1, e_err, accept, pick1, al;
        logic [DW-1:0] e_rd;
        acc_i = -1; rsp_i = -1;
        e_g0 = 0; e_g1 = 0; e_we = 0; e_rv0 = 0; e_rv1 = 0; e_err = 0; e_rd = '0;
        foreach (q[i]) begin
            if (q[i].gcyc + 1 == cyc) acc_i = i;
            if (q[i].gcyc + 2 == cyc) rsp_i = i;
        end
        if (!reset) begin
            if (acc_i >= 0) begin
                al   = (q[acc_i].addr[1:0] == 2'b00);
                key  = int'(q[acc_i].addr >> 2);
                e_we = q[acc_i].we && al;
                chk("mem_a", mem_a, q[acc_i].addr);
                chk("mem_wd", mem_wd, q[acc_i].wdata);
                q[acc_i].rdata = (!q[acc_i].we && al) ?
                                 (shadow.exists(key) ? shadow[key] : '0) : '0;
                if (e_we) shadow[key] = q[acc_i].wdata;
            end
            if (rsp_i >= 0) begin
                e_rv0 = (q[rsp_i].port == 0);
                e_rv1 = (q[rsp_i].port == 1);
                e_rd  = q[rsp_i].rdata;
                e_err = (q[rsp_i].addr[1:0] != 2'b00);
            end
            accept = (acc_i < 0);
            pick1  = m1_req && (!m0_req || rr == 0);
            e_g1   = accept && pick1;
            e_g0   = accept && m0_req && !pick1;
        end
        chk("m0_gnt", m0_gnt, e_g0);
        chk("m1_gnt", m1_gnt, e_g1);
        chk("mem_we", mem_we, e_we);
        chk("m0_rvalid", m0_rvalid, e_rv0);
        chk("m1_rvalid", m1_rvalid, e_rv1);
        if (e_rv0) begin chk("m0_rdata", m0_rdata, e_rd); chk("m0_err", m0_err, e_err); end
        if (e_rv1) begin chk("m1_rdata", m1_rdata, e_rd); chk("m1_err", m1_err, e_err); end
        if (prev_reset && !reset) begin
            chk("post_reset_mem_a", mem_a, 0);
            chk("post_reset_mem_wd", mem_wd, 0);
            chk("post_reset_rdata", {m0_rdata, m1_rdata}, 0);
            chk("post_reset_err", {m0_err, m1_err}, 0);
        end

        // logs
        if (m0_rvalid) begin r_cnt[0]++; r_cyc[0] = cyc; r_data[0] = m0_rdata; r_err[0] = m0_err; end
        if (m1_rvalid) begin r_cnt[1]++; r_cyc[1] = cyc; r_data[1] = m1_rdata; r_err[1] = m1_err; end
        if (m0_gnt) begin g_cnt[0]++; gport.push_back(0); gcy.push_back(cyc); end
        if (m1_gnt) begin g_cnt[1]++; gport.push_back(1); gcy.push_back(cyc); end
        if (mem_we) we_cnt++;

        // advance model to the next cycle
        if (reset) begin
            q.delete();
            rr = 1;
        end else begin
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].gcyc + 2 <= cyc) q.delete(i);
            if (e_g0 || e_g1) begin
                txn_t t;
                t.port  = e_g1 ? 1 : 0;
                t.we    = e_g1 ? m1_we : m0_we;
                t.addr  = e_g1 ? m1_addr : m0_addr;
                t.wdata = e_g1 ? m1_wdata : m0_wdata;
                t.gcyc  = cyc;
                t.rdata = '0;
                q.push_back(t);
                rr = t.port;
            end
        end
        prev_reset = reset;
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int p, input bit rq, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin m0_req = rq; m0_we = we; m0_addr = a; m0_wdata = d; end
        else        begin m1_req = rq; m1_we = we; m1_addr = a; m1_wdata = d; end
    endtask

    // Raise a request, hold it until granted, drop it right after the grant
    // edge. Returns the grant cycle number (-1 on timeout).
    task automatic do_req(input int p, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int gc);
        gc = -1;
        drive(p, 1'b1, we, a, d);
        for (int k = 0; k < 20 && gc < 0; k++) begin
            @(negedge clk); #1;
            if ((p == 0) ? m0_gnt : m1_gnt) gc = cyc - 1;
        end
        if (gc < 0) begin
            errors++;
            $display("FAIL grant_timeout: port %0d got no grant, required one within 20 cycles", p);
        end
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int g0, g1, n0, nw;
        // reset with a request pending: no grant may appear
        m0_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("gnt_in_reset", m0_gnt, 0);
        chk("mem_we_in_reset", mem_we, 0);
        m0_req = 1'b0;
        reset  = 1'b0;
        @(posedge clk); #1;
        chk("reset_mem_a", mem_a, 0);

        // 1: store then load on port 0
        do_req(0, 1'b1, 32'h4, 32'hA5A5_A5A5, g0);
        settle();
        chk("t1_store_we_count", we_cnt, 1);
        do_req(0, 1'b0, 32'h4, '0, g0);
        settle();
        chk("t1_load_rdata", r_data[0], 32'hA5A5_A5A5);
        chk("t1_load_err", r_err[0], 0);
        chk("t1_latency", r_cyc[0] - g0, 2);

        // 2: simultaneous requests after reset, port 0 wins the first tie
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
        n0 = r_cnt[0];
        fork
            do_req(0, 1'b0, 32'h8, '0, g0);
            do_req(1, 1'b1, 32'hC, 32'hDEAD_BEAF, g1);
        join
        settle();
        chk("t2_m1_after_m0", g1 - g0, 2);
        chk("t2_m1_latency", r_cyc[1] - g1, 2);
        chk("t2_m0_resp_count", r_cnt[0] - n0, 1);
        chk("t2_m0_rdata", r_data[0], 0);
        do_req(1, 1'b0, 32'hC, '0, g1);
        settle();
        chk("t2_m1_readback", r_data[1], 32'hDEAD_BEAF);

        // 3: both hold requests for six grants
        gport.delete(); gcy.delete();
        drive(0, 1'b1, 1'b0, 32'h4, '0);
        drive(1, 1'b1, 1'b0, 32'hC, '0);
        for (int k = 0; k < 40 && gport.size() < 6; k++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        settle();
        chk("t3_grant_count", gport.size(), 6);
        if (gport.size() >= 6) begin
            for (int i = 0; i < 6; i++) chk("t3_grant_port", gport[i], i % 2);
            for (int i = 1; i < 6; i++) chk("t3_grant_spacing", gcy[i] - gcy[i-1], 2);
        end

        // 4: misaligned store on port 1
        nw = we_cnt;
        do_req(1, 1'b1, 32'h6, 32'h1234_5678, g1);
        settle();
        chk("t4_no_write", we_cnt - nw, 0);
        chk("t4_err", r_err[1], 1);
        chk("t4_rdata", r_data[1], 0);
        do_req(0, 1'b0, 32'h4, '0, g0);
        settle();
        chk("t4_prior_value", r_data[0], 32'hA5A5_A5A5);
        chk("t4_aligned_err", r_err[0], 0);

        // 5: reset during the ACCESS cycle of a store
        do_req(0, 1'b1, 32'h10, 32'h1111_2222, g0);
        settle();
        n0 = r_cnt[0];
        nw = we_cnt;
        do_req(0, 1'b1, 32'h10, 32'h5A5A_5A5A, g0);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_mem_we_dropped", mem_we, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_outputs_zero", {m0_gnt, m0_rvalid, m0_err, mem_we, mem_a, mem_wd}, 0);
        settle();
        chk("t5_no_rvalid", r_cnt[0] - n0, 0);
        chk("t5_no_write", we_cnt - nw, 0);
        do_req(0, 1'b0, 32'h10, '0, g0);
        settle();
        chk("t5_old_contents", r_data[0], 32'h1111_2222);

        // 6: port 0 request pulsed only during ACCESS
        do_req(1, 1'b0, 32'h4, '0, g1);
        n0 = g_cnt[0];
        nw = we_cnt;
        drive(0, 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        settle();
        chk("t6_no_gnt", g_cnt[0] - n0, 0);
        chk("t6_no_write", we_cnt - nw, 0);
        do_req(0, 1'b0, 32'h20, '0, g0);
        settle();
        chk("t6_mem_untouched", r_data[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
